// File: rtl/key_scan_ctrl.sv
// Front-panel key scanner: synchronises five active-low key lines, debounces
// press/release and emits one event per press followed by auto-repeat events.
module key_scan_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_MS   = 20,
  parameter int unsigned HOLD_MS  = 1000,
  parameter int unsigned RPT_MS   = 200
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [4:0]  key_in,
  input  logic        scan_en,
  output logic [15:0] key_data,
  output logic        key_data_valid,
  output logic        key_busy
);

  localparam int unsigned KEY_W   = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_MAX = (DEB_MS > HOLD_MS) ?
                                    ((DEB_MS > RPT_MS) ? DEB_MS : RPT_MS) :
                                    ((HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [KEY_W-1:0] KEY_IDLE = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_REPEAT,
    S_RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [KEY_W-1:0]   key_m, key_s;
  logic [KEY_W-1:0]   cand, cand_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick_c;
  logic               match_c;
  logic               emit_c;

  // Two-flop synchroniser for the asynchronous key lines
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= KEY_IDLE;
      key_s <= KEY_IDLE;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

  // Free-running scan tick
  assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  assign match_c = (key_s == cand);

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= KEY_IDLE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // Next-state; a key mismatch always takes priority over an emit tick
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    if (!scan_en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_s != KEY_IDLE) begin
            state_nxt = S_DEBOUNCE;
            cand_nxt  = key_s;
            cnt_nxt   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (!match_c) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (emit_c) begin
            state_nxt = S_PRESSED;
            cnt_nxt   = '0;
          end else if (tick_c) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_PRESSED: begin
          if (!match_c) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
          end else if (emit_c) begin
            state_nxt = S_REPEAT;
            cnt_nxt   = '0;
          end else if (tick_c) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!match_c) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
          end else if (emit_c) begin
            cnt_nxt = '0;
          end else if (tick_c) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (key_s != KEY_IDLE) begin
            cnt_nxt = '0;
          end else if (tick_c) begin
            if (cnt == CNT_W'(DEB_MS - 1)) begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Emit decision: terminal tick in a qualifying state with the key still held
  always_comb begin
    emit_c = 1'b0;
    if (scan_en && match_c && tick_c) begin
      case (state)
        S_DEBOUNCE: emit_c = (cnt == CNT_W'(DEB_MS - 1));
        S_PRESSED:  emit_c = (cnt == CNT_W'(HOLD_MS - 1));
        S_REPEAT:   emit_c = (cnt == CNT_W'(RPT_MS - 1));
        default:    emit_c = 1'b0;
      endcase
    end
  end

  // Registered outputs; key_data holds its last code between events
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      key_data       <= '0;
      key_data_valid <= 1'b0;
      key_busy       <= 1'b0;
    end else begin
      key_data_valid <= emit_c;
      if (emit_c) begin
        key_data <= DATA_W'(cand);
      end
      key_busy <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: scoreboard of expected key events with
// timing windows, a table of press/hold vectors and hand-written corner cases.
module tb_key_scan_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [4:0]  key_in;
  logic        scan_en;
  logic [15:0] key_data;
  logic        key_data_valid;
  logic        key_busy;

  key_scan_ctrl #(
    .TICK_DIV (4),
    .DEB_MS   (3),
    .HOLD_MS  (8),
    .RPT_MS   (2)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .key_in         (key_in),
    .scan_en        (scan_en),
    .key_data       (key_data),
    .key_data_valid (key_data_valid),
    .key_busy       (key_busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] data;
    int          lo;
    int          hi;
  } ev_t;

  typedef struct {
    logic [4:0] key;
    int         hold_cyc;
    int         n_ev;
  } vec_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ev_seen = 0;
  int   valid_cnt = 0;
  logic pulse_chk = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [4:0] k, input int lo, input int hi);
    ev_t e;
    e.data = 16'(k);
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  // Event n of a press driven at cycle c0: first after the debounce, then hold, then repeats
  task automatic push_press(input logic [4:0] k, input int c0, input int n);
    for (int i = 0; i < n; i++) begin
      int off;
      off = (i == 0) ? 0 : 32 + 8 * (i - 1);
      push_ev(k, c0 + 12 + off, c0 + 15 + off);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Scoreboard monitor: matches each strobe against the oldest expected event
  always @(negedge clk_sys) begin
    if (pulse_chk) check("pulse_width", 32'(key_data_valid), 32'd0);
    pulse_chk = key_data_valid;
    if (key_data_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key_data 0x%0h, expected no event (cycle %0d)", key_data, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        ev_seen++;
        check("event_data", 32'(key_data), 32'(e.data));
        checks++;
        if (cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL event_time: got cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
      checks++;
      errors++;
      $display("FAIL missing_event: got none by cycle %0d, expected 0x%0h by %0d", cyc, exp_q[0].data, exp_q[0].hi);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    vec_t        vt[6];
    logic [15:0] exp_last;
    int          c0;
    int          c1;
    int          seen0;
    int          rises;
    logic        busy_prev;

    vt[0] = '{5'h1d, 6,  0};
    vt[1] = '{5'h1e, 24, 1};
    vt[2] = '{5'h0f, 46, 2};
    vt[3] = '{5'h1d, 80, 6};
    vt[4] = '{5'h00, 24, 1};
    vt[5] = '{5'h17, 46, 2};

    rst_n   = 1'b0;
    key_in  = 5'h1f;
    scan_en = 1'b1;
    wait_cyc(3);
    check("reset_key_data", 32'(key_data), 32'd0);
    check("reset_valid", 32'(key_data_valid), 32'd0);
    check("reset_busy", 32'(key_busy), 32'd0);
    rst_n = 1'b1;

    // Idle lines: nothing happens
    wait_cyc(100);
    check("idle_key_data", 32'(key_data), 32'd0);
    check("idle_busy", 32'(key_busy), 32'd0);
    check("idle_no_valid", 32'(valid_cnt), 32'd0);
    exp_last = 16'd0;

    // Table of press/hold vectors
    for (int i = 0; i < 6; i++) begin
      c0     = cyc;
      seen0  = ev_seen;
      key_in = vt[i].key;
      push_press(vt[i].key, c0, vt[i].n_ev);
      wait_cyc(vt[i].hold_cyc);
      check($sformatf("vec%0d_busy_held", i), 32'(key_busy), 32'd1);
      key_in = 5'h1f;
      wait_cyc(24);
      if (vt[i].n_ev > 0) exp_last = 16'(vt[i].key);
      check($sformatf("vec%0d_busy_after", i), 32'(key_busy), 32'd0);
      check($sformatf("vec%0d_event_count", i), 32'(ev_seen - seen0), 32'(vt[i].n_ev));
      check($sformatf("vec%0d_key_data", i), 32'(key_data), 32'(exp_last));
    end

    // Bouncing key, one tick per level: never qualifies, busy follows each bounce
    rises     = 0;
    busy_prev = key_busy;
    for (int j = 0; j < 52; j++) begin
      key_in = (j < 40 && (j % 8) < 4) ? 5'h1d : 5'h1f;
      @(negedge clk_sys);
      if (key_busy && !busy_prev) rises++;
      busy_prev = key_busy;
    end
    check("bounce_busy_rises", 32'(rises), 32'd5);
    check("bounce_busy_end", 32'(key_busy), 32'd0);
    check("bounce_key_data", 32'(key_data), 32'(exp_last));

    // Glitch during release restarts the release debounce
    c0     = cyc;
    seen0  = ev_seen;
    key_in = 5'h1d;
    push_press(5'h1d, c0, 1);
    wait_cyc(24);
    key_in = 5'h1f;
    wait_cyc(4);
    key_in = 5'h1d;
    wait_cyc(4);
    key_in = 5'h1f;
    wait_cyc(9);
    check("glitch_busy_held", 32'(key_busy), 32'd1);
    wait_cyc(7);
    check("glitch_busy_clear", 32'(key_busy), 32'd0);
    check("glitch_event_count", 32'(ev_seen - seen0), 32'd1);
    exp_last = 16'h001d;

    // scan_en drop mid-debounce, then a full debounce after re-enable
    c0     = cyc;
    seen0  = ev_seen;
    key_in = 5'h1d;
    wait_cyc(8);
    scan_en = 1'b0;
    wait_cyc(2);
    check("scan_off_busy", 32'(key_busy), 32'd0);
    wait_cyc(6);
    check("scan_off_busy_held", 32'(key_busy), 32'd0);
    scan_en = 1'b1;
    c1 = cyc;
    push_ev(5'h1d, c1 + 10, c1 + 13);
    wait_cyc(20);
    key_in = 5'h1f;
    wait_cyc(24);
    check("scan_event_count", 32'(ev_seen - seen0), 32'd1);
    check("scan_busy_after", 32'(key_busy), 32'd0);

    // Asynchronous reset while auto-repeating
    c0     = cyc;
    seen0  = ev_seen;
    key_in = 5'h1e;
    push_press(5'h1e, c0, 2);
    wait_cyc(50);
    rst_n = 1'b0;
    #1;
    check("async_rst_key_data", 32'(key_data), 32'd0);
    check("async_rst_valid", 32'(key_data_valid), 32'd0);
    check("async_rst_busy", 32'(key_busy), 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    c1 = cyc;
    push_ev(5'h1e, c1 + 12, c1 + 15);
    wait_cyc(24);
    key_in = 5'h1f;
    wait_cyc(24);
    check("rst_event_count", 32'(ev_seen - seen0), 32'd3);
    check("rst_key_data", 32'(key_data), 32'h1e);
    check("rst_busy_after", 32'(key_busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
